// File: rtl/countdown_seq_ctrl_if.sv
// Front-panel / datapath bundle for the countdown sequencing controller.
interface countdown_seq_ctrl_if;
  logic       start;
  logic       pause;
  logic       clr;
  logic       borrow;
  logic [7:0] x;
  logic       cnt_en;
  logic       load;
  logic       alarm;
  logic       warn;
  logic [3:0] round_cnt;
  logic [2:0] state;

  // Panel/datapath side: drives buttons and count, observes controls.
  modport master (
    output start, pause, clr, borrow, x,
    input  cnt_en, load, alarm, warn, round_cnt, state
  );

  // Controller side.
  modport slave (
    input  start, pause, clr, borrow, x,
    output cnt_en, load, alarm, warn, round_cnt, state
  );
endinterface

// File: rtl/countdown_seq_ctrl.sv
// Sequencing controller: button edges -> load/cnt_en, round counting,
// timed end-of-sequence alarm and low-time warning.
module countdown_seq_ctrl #(
  parameter int unsigned ROUNDS       = 3,
  parameter int unsigned ALARM_CYCLES = 50000000,
  parameter logic [7:0]  WARN_VAL     = 8'h10
) (
  input logic                 clk,
  input logic                 rst_n,
  countdown_seq_ctrl_if.slave bus
);

  localparam int unsigned TIMER_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam int unsigned RC_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [RC_W-1:0]    round_q, round_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               start_prev_q, pause_prev_q, clr_prev_q, borrow_prev_q;
  logic               load_q, cnt_en_q, alarm_q, warn_q;
  logic               warn_d;

  logic start_ev, pause_ev, clr_ev, borrow_ev;

  assign start_ev  = bus.start  & ~start_prev_q;
  assign pause_ev  = bus.pause  & ~pause_prev_q;
  assign clr_ev    = bus.clr    & ~clr_prev_q;
  assign borrow_ev = bus.borrow & ~borrow_prev_q;

  // Next-state, round count and alarm timer; priority clr > borrow > pause > start.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    timer_d = timer_q;
    warn_d  = (state_q == ST_RUN) && (bus.x <= WARN_VAL);
    if (clr_ev && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      round_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ev && !clr_ev) begin
            state_d = ST_LOAD;
            round_d = '0;
          end
        end
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (borrow_ev) begin
            if ((5'(round_q) + 5'd1) == 5'(ROUNDS)) begin
              state_d = ST_ALARM;
              round_d = RC_W'(ROUNDS);
              timer_d = TIMER_W'(ALARM_CYCLES - 1);
            end else begin
              state_d = ST_LOAD;
              round_d = round_q + RC_W'(1);
            end
          end else if (pause_ev) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_ev) state_d = ST_RUN;
        end
        ST_ALARM: begin
          if ((timer_q == '0) || start_ev) begin
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          round_d = '0;
          warn_d  = 1'b0;
        end
      endcase
    end
  end

  // State, history and registered Moore outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      round_q       <= '0;
      timer_q       <= '0;
      start_prev_q  <= 1'b0;
      pause_prev_q  <= 1'b0;
      clr_prev_q    <= 1'b0;
      borrow_prev_q <= 1'b0;
      load_q        <= 1'b0;
      cnt_en_q      <= 1'b0;
      alarm_q       <= 1'b0;
      warn_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      timer_q       <= timer_d;
      start_prev_q  <= bus.start;
      pause_prev_q  <= bus.pause;
      clr_prev_q    <= bus.clr;
      borrow_prev_q <= bus.borrow;
      load_q        <= (state_d == ST_LOAD);
      cnt_en_q      <= (state_d == ST_RUN);
      alarm_q       <= (state_d == ST_ALARM);
      warn_q        <= warn_d;
    end
  end

  assign bus.load      = load_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.alarm     = alarm_q;
  assign bus.warn      = warn_q;
  assign bus.round_cnt = round_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_countdown_seq_ctrl.sv
// Bench for countdown_seq_ctrl: directed vector table, model-checked random
// traffic, and hand sequences for alarm acknowledge/clear and async reset.
module tb_countdown_seq_ctrl;
  localparam int unsigned ROUNDS = 2;
  localparam int unsigned ACYC   = 8;
  localparam logic [7:0]  WARN   = 8'h10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  countdown_seq_ctrl_if bus ();

  countdown_seq_ctrl #(.ROUNDS(ROUNDS), .ALARM_CYCLES(ACYC), .WARN_VAL(WARN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase codes are the documented state codes.
  int m_ph, m_round, m_left;
  bit m_warn, ps, pp, pc, pb;

  task automatic m_reset();
    m_ph = 0; m_round = 0; m_left = 0; m_warn = 0;
    ps = 0; pp = 0; pc = 0; pb = 0;
  endtask

  task automatic m_step(input bit s, input bit p, input bit c, input bit b, input logic [7:0] xv);
    bit es, ep, ec, eb, nw;
    int nph;
    es = s && !ps; ep = p && !pp; ec = c && !pc; eb = b && !pb;
    ps = s; pp = p; pc = c; pb = b;
    nw  = (m_ph == 2) && (xv <= WARN);
    nph = m_ph;
    if (ec && m_ph != 0) begin
      nph = 0; m_round = 0;
    end else if (m_ph == 0) begin
      if (es && !ec) begin nph = 1; m_round = 0; end
    end else if (m_ph == 1) begin
      nph = 2;
    end else if (m_ph == 2) begin
      if (eb) begin
        if (m_round + 1 == int'(ROUNDS)) begin
          nph = 4; m_round = ROUNDS; m_left = ACYC;
        end else begin
          nph = 1; m_round = m_round + 1;
        end
      end else if (ep) nph = 3;
    end else if (m_ph == 3) begin
      if (es) nph = 2;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0 || es) nph = 0;
    end
    m_ph = nph;
    m_warn = nw;
  endtask

  // Compare every output against expected state/round/warn; decodes follow the state.
  task automatic chk(input string nm, input int st, input int rc, input bit w);
    logic [10:0] act, exp;
    exp = {3'(st), 4'(rc), st == 1, st == 2, st == 4, w};
    act = {bus.state, bus.round_cnt, bus.load, bus.cnt_en, bus.alarm, bus.warn};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got st=%0d rc=%0d ld=%b en=%b al=%b wn=%b, expected st=%0d rc=%0d ld=%b en=%b al=%b wn=%b",
               nm, act[10:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[10:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input bit s, input bit p, input bit c, input bit b, input logic [7:0] xv);
    bus.start = s; bus.pause = p; bus.clr = c; bus.borrow = b; bus.x = xv;
  endtask

  task automatic cyc(input string nm, input bit s, input bit p, input bit c, input bit b, input logic [7:0] xv);
    drive(s, p, c, b, xv);
    @(posedge clk); #1;
    m_step(s, p, c, b, xv);
    chk(nm, m_ph, m_round, m_warn);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 8'h45);
    rst_n = 1'b0;
    m_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit s, p, c, b;
    logic [7:0] x;
    int st, rc;
    bit w;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit s, input bit p, input bit c, input bit b, input logic [7:0] xv,
                     input int st, input int rc, input bit w);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.b = b; v.x = xv; v.st = st; v.rc = rc; v.w = w;
    tbl.push_back(v);
  endtask

  initial begin
    // start held 5 cycles: one load pulse, then RUN
    add(1,0,0,0,8'h45, 1,0,0); add(1,0,0,0,8'h45, 2,0,0); add(1,0,0,0,8'h45, 2,0,0);
    add(1,0,0,0,8'h45, 2,0,0); add(1,0,0,0,8'h45, 2,0,0); add(0,0,0,0,8'h45, 2,0,0);
    // borrow held 3 cycles: single reload
    add(0,0,0,1,8'h45, 1,1,0); add(0,0,0,1,8'h45, 2,1,0); add(0,0,0,1,8'h45, 2,1,0);
    add(0,0,0,0,8'h45, 2,1,0);
    // pause, borrow ignored while paused, resume
    add(0,1,0,0,8'h45, 3,1,0); add(0,0,0,1,8'h45, 3,1,0); add(0,0,0,0,8'h45, 3,1,0);
    add(1,0,0,0,8'h45, 2,1,0);
    // warn threshold: 0x11 no, 0x10 yes, then off in PAUSE
    add(0,0,0,0,8'h11, 2,1,0); add(0,0,0,0,8'h11, 2,1,0); add(0,0,0,0,8'h10, 2,1,1);
    add(0,1,0,0,8'h10, 3,1,1); add(0,0,0,0,8'h10, 3,1,0);
    add(1,0,0,0,8'h45, 2,1,0);
    // final borrow -> 8-cycle alarm -> IDLE holding round count
    add(0,0,0,1,8'h45, 4,2,0);
    for (int i = 0; i < 7; i++) add(0,0,0,0,8'h45, 4,2,0);
    add(0,0,0,0,8'h45, 0,2,0); add(0,0,0,0,8'h45, 0,2,0);
    // new sequence; borrow+pause together -> reload wins; clr
    add(1,0,0,0,8'h45, 1,0,0); add(0,0,0,0,8'h45, 2,0,0);
    add(0,1,0,1,8'h45, 1,1,0); add(0,0,0,0,8'h45, 2,1,0); add(0,0,0,0,8'h45, 2,1,0);
    add(0,0,1,0,8'h45, 0,0,0); add(0,0,0,0,8'h45, 0,0,0);

    do_reset();
    chk("reset", 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].b, tbl[i].x);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].rc, tbl[i].w);
    end

    // Early acknowledge during ALARM
    do_reset();
    cyc("ack_a", 1,0,0,0,8'h45); cyc("ack_b", 0,0,0,0,8'h45);
    cyc("ack_c", 0,0,0,1,8'h45); cyc("ack_d", 0,0,0,0,8'h45);
    cyc("ack_e", 0,0,0,1,8'h45); cyc("ack_f", 0,0,0,0,8'h45);
    cyc("ack_g", 1,0,0,0,8'h45);
    chk("ack_idle", 0, 2, 0);
    cyc("ack_h", 0,0,0,0,8'h45); cyc("ack_restart", 1,0,0,0,8'h45);
    chk("restart_load", 1, 0, 0);

    // clr during ALARM
    cyc("clr_a", 0,0,0,0,8'h45);
    cyc("clr_b", 0,0,0,1,8'h45); cyc("clr_c", 0,0,0,0,8'h45);
    cyc("clr_d", 0,0,0,1,8'h45); cyc("clr_e", 0,0,1,0,8'h45);
    chk("clr_alarm", 0, 0, 0);

    // Async reset in the middle of ALARM
    cyc("rst_a", 1,0,0,0,8'h45); cyc("rst_b", 0,0,0,0,8'h45);
    cyc("rst_c", 0,0,0,1,8'h45); cyc("rst_d", 0,0,0,0,8'h45);
    cyc("rst_e", 0,0,0,1,8'h45); cyc("rst_f", 0,0,0,0,8'h45);
    chk("rst_in_alarm", 4, 2, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 0, 0, 0);
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_rst_idle", 0,0,0,0,8'h45);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] xv;
      xv = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      cyc("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0), xv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/countdown_seq_ctrl.md
Name: countdown_seq_ctrl

Overview:
Sequencing controller for the 60 s countdown datapath (second-pulse generator plus BCD down-counter). It turns raw start/pause/clear buttons into the counter's `cnt_en` and `load` controls and watches the counter's `borrow`. It auto-reloads the counter for a programmed number of rounds, raises a timed alarm after the last round, and flags a low-time warning. It sits between the front-panel inputs and the countdown top.

Parameters:
ROUNDS, 3, number of full countdowns before the alarm; legal range 1..15.
ALARM_CYCLES, 50000000, clk cycles the alarm stays asserted; must be at least 1.
WARN_VAL, 8'h10, BCD threshold at or below which warn asserts while running.

Ports:
clk  input  1  system clock, same domain as the countdown datapath.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  start/resume/acknowledge button, synchronous, level.
pause  input  1  pause button, synchronous, level.
clr  input  1  abort/clear button, synchronous, level.
borrow  input  1  countdown wrap/borrow flag from the datapath; may stay high for many cycles.
x  input  8  current BCD count from the datapath (tens in [7:4], units in [3:0]).
cnt_en  output  1  count enable to the datapath.
load  output  1  load/preset strobe to the datapath.
alarm  output  1  end-of-sequence alarm.
warn  output  1  low-time warning.
round_cnt  output  4  completed rounds in the current sequence.
state  output  3  FSM state code, for debug and display.

Behaviour:
- One clock, `clk`. Reset is asynchronous, active-low on `rst_n`, and applies to all registers.
- Reset values: state=IDLE, cnt_en=0, load=0, alarm=0, warn=0, round_cnt=0, all edge-detect history registers=0.
- Edge detection: `start`, `pause`, `clr` and `borrow` each have a previous-sample register. An event is in&~in_prev, evaluated in the same cycle. The FSM acts on it at that clock edge, so an input held high produces exactly one event.
- States and codes: IDLE=0, LOAD=1, RUN=2, PAUSE=3, ALARM=4.
- Moore outputs, decoded from the state register:
  - load=1 only in LOAD.
  - cnt_en=1 only in RUN.
  - alarm=1 only in ALARM.
- Event priority within one cycle: clr > borrow > pause > start.
- clr event in any state other than IDLE: go to IDLE and set round_cnt=0.
- IDLE: start event -> LOAD, round_cnt=0.
- LOAD: unconditional -> RUN after exactly one cycle. load is therefore a 1-cycle pulse.
- RUN, borrow event:
  - If round_cnt+1==ROUNDS -> ALARM, round_cnt=ROUNDS. round_cnt holds this value through ALARM.
  - Otherwise -> LOAD, round_cnt+=1 (auto-reload).
- RUN, pause event (no borrow event in the same cycle) -> PAUSE. A start event in RUN is ignored.
- PAUSE: start event -> RUN. A borrow event in PAUSE is ignored.
- ALARM timing:
  - An internal timer loads ALARM_CYCLES-1 on entry and decrements each cycle.
  - When the timer is 0, or on a start event (acknowledge), go to IDLE. round_cnt is retained in IDLE until the next start.
  - With no acknowledge, alarm is high for exactly ALARM_CYCLES cycles.
- warn: registered, one cycle of latency. Its next value is 1 iff state==RUN and x<=WARN_VAL, using an unsigned 8-bit compare (valid for BCD). It is 0 in every other state.
- Simultaneous borrow and pause events in RUN: borrow wins, and the pause event is lost.
- An illegal state code recovers to IDLE with all outputs deasserted.
- Reset asserted mid-sequence: all outputs are 0 asynchronously. After release the controller waits in IDLE for a new start event.

Test Plan:
1. ROUNDS=2, ALARM_CYCLES=8. Reset, then hold start high for 5 cycles -> exactly one load pulse of 1 cycle, then cnt_en=1 from the next cycle; state goes 0->1->2.
2. In RUN, pulse borrow high for 3 cycles -> one LOAD cycle, round_cnt=1, back to RUN. A second borrow -> state=4, alarm high for exactly 8 cycles, round_cnt=2, then IDLE with cnt_en=0.
3. In RUN, pause -> cnt_en=0 the next cycle (PAUSE). A borrow while paused leaves round_cnt unchanged. start -> RUN, and round_cnt is still unchanged.
4. Borrow and pause rising in the same cycle during round 1 -> LOAD taken, round_cnt=1, PAUSE not entered. clr in RUN -> IDLE, round_cnt=0.
5. Drive x=8'h11 then 8'h10 while in RUN -> warn=0, then warn=1 one cycle later. Enter PAUSE -> warn=0.
6. Assert rst_n=0 during ALARM -> alarm, cnt_en and round_cnt are 0 immediately, without waiting for a clk edge. During ALARM, start acknowledges early -> IDLE on the next edge.
